// File: rtl/rvc_fetch_pkg.sv
// Shared types and helpers for the RV32IC fetch aligner.
package rvc_fetch_pkg;
  localparam int unsigned ILEN = 32;
  localparam int unsigned HW   = 16;
  localparam logic [31:0] WORD_MASK = ~32'h3;

  typedef logic [HW-1:0] halfword_t;

  // Number of halfwords moved into or out of the buffer in one cycle.
  typedef enum logic [1:0] {
    MOVE_NONE = 2'd0,
    MOVE_ONE  = 2'd1,
    MOVE_TWO  = 2'd2
  } hw_move_e;

  function automatic logic is_compressed(input halfword_t hw);
    return hw[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/rvc_fetch_aligner_hw_queue.sv
// Circular halfword FIFO: up to two pushes and two pops per cycle, head exposed as hw0/hw1.
module rvc_hw_queue
  import rvc_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  hw_move_e                   push,
  input  halfword_t                  push_hw0,
  input  halfword_t                  push_hw1,
  input  hw_move_e                   pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output halfword_t                  hw0,
  output halfword_t                  hw1
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW+1:0] DEPTH_W = DEPTH[PW+1:0];

  halfword_t     mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;

  // Pointer advance modulo DEPTH; DEPTH need not be a power of two.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [1:0] n);
    logic [PW+1:0] s;
    s = {2'b00, p} + {{PW{1'b0}}, n};
    if (s >= DEPTH_W) s = s - DEPTH_W;
    return s[PW-1:0];
  endfunction

  assign push_n = push;
  assign pop_n  = pop;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= wrap_add(rd_ptr, pop_n);
      wr_ptr <= wrap_add(wr_ptr, push_n);
      count  <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (push_n != 2'd0) mem[wr_ptr] <= push_hw0;
      if (push_n == 2'd2) mem[wrap_add(wr_ptr, 2'd1)] <= push_hw1;
    end
  end

  assign hw0 = mem[rd_ptr];
  assign hw1 = mem[wrap_add(rd_ptr, 2'd1)];
endmodule

// File: rtl/rvc_fetch_aligner.sv
// RV32IC fetch stage: word fetches from imem, realigned into 16/32-bit instructions for decode.
module rvc_fetch_aligner
  import rvc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned BUF_HW   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_compressed_o
);
  localparam int unsigned CW = $clog2(BUF_HW + 1);
  localparam logic [CW-1:0] REQ_LIMIT = CW'(BUF_HW - 2);

  logic [31:0]   fetch_pc;
  logic [31:0]   head_pc;
  logic          outstanding;
  logic          drop;
  logic          skip_low;
  logic [CW-1:0] count;
  halfword_t     hw0;
  halfword_t     hw1;
  halfword_t     push_hw0;
  hw_move_e      push;
  hw_move_e      pop;
  logic          granted;
  logic          rsp;
  logic          accept;
  logic          hw0_c;

  rvc_hw_queue #(.DEPTH(BUF_HW)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_i),
    .push     (push),
    .push_hw0 (push_hw0),
    .push_hw1 (imem_rdata_i[31:16]),
    .pop      (pop),
    .count    (count),
    .hw0      (hw0),
    .hw1      (hw1)
  );

  // Only request when a full word is guaranteed to fit on return.
  assign imem_req_o  = !rst && !outstanding && !drop && (count <= REQ_LIMIT);
  assign imem_addr_o = fetch_pc;
  assign granted     = imem_req_o && imem_gnt_i;
  assign rsp         = imem_rvalid_i && outstanding;
  assign hw0_c       = is_compressed(hw0);

  always_comb begin
    inst_valid_o = 1'b0;
    inst_o       = '0;
    if (hw0_c && count >= CW'(1)) begin
      inst_valid_o = 1'b1;
      inst_o       = {16'h0, hw0};
    end else if (!hw0_c && count >= CW'(2)) begin
      inst_valid_o = 1'b1;
      inst_o       = {hw1, hw0};
    end
  end

  assign inst_pc_o         = head_pc;
  assign inst_compressed_o = inst_o[1:0] != 2'b11;
  assign accept            = inst_valid_o && inst_ready_i && !redirect_i;

  always_comb begin
    push     = MOVE_NONE;
    pop      = MOVE_NONE;
    push_hw0 = imem_rdata_i[15:0];
    if (rsp && !drop && !redirect_i) begin
      push = skip_low ? MOVE_ONE : MOVE_TWO;
      if (skip_low) push_hw0 = imem_rdata_i[31:16];
    end
    if (accept) pop = hw0_c ? MOVE_ONE : MOVE_TWO;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC & WORD_MASK;
      head_pc     <= RESET_PC & ~32'h1;
      skip_low    <= RESET_PC[1];
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else begin
      if (granted) begin
        outstanding <= 1'b1;
        fetch_pc    <= fetch_pc + 32'd4;
      end else if (rsp) begin
        outstanding <= 1'b0;
        drop        <= 1'b0;
      end
      if (push != MOVE_NONE) skip_low <= 1'b0;
      if (accept) head_pc <= head_pc + (hw0_c ? 32'd2 : 32'd4);
      // Redirect overrides the updates above; drop covers a request still owed a response.
      if (redirect_i) begin
        fetch_pc <= redirect_pc_i & WORD_MASK;
        head_pc  <= redirect_pc_i & ~32'h1;
        skip_low <= redirect_pc_i[1];
        drop     <= granted || (outstanding && !imem_rvalid_i);
      end
    end
  end
endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Bench for rvc_fetch_aligner: random imem responder, instruction-stream reference model.
module tb_rvc_fetch_aligner;
  typedef struct packed {
    logic        redir;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        c;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_ready_i;

  logic        a_req, a_valid, a_c, b_req, b_valid, b_c;
  logic [31:0] a_addr, a_inst, a_pc, b_addr, b_inst, b_pc;
  logic        o_req, o_valid, o_c;
  logic [31:0] o_addr, o_inst, o_pc;
  logic        sel;

  always #5 clk = ~clk;

  rvc_fetch_aligner #(.RESET_PC(32'h0), .BUF_HW(4)) dut (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(a_req), .imem_addr_o(a_addr), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(a_valid), .inst_ready_i(inst_ready_i), .inst_o(a_inst),
    .inst_pc_o(a_pc), .inst_compressed_o(a_c)
  );

  rvc_fetch_aligner #(.RESET_PC(32'h20), .BUF_HW(4)) dut_rst20 (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(b_req), .imem_addr_o(b_addr), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(b_valid), .inst_ready_i(inst_ready_i), .inst_o(b_inst),
    .inst_pc_o(b_pc), .inst_compressed_o(b_c)
  );

  assign o_req   = sel ? b_req   : a_req;
  assign o_addr  = sel ? b_addr  : a_addr;
  assign o_valid = sel ? b_valid : a_valid;
  assign o_inst  = sel ? b_inst  : a_inst;
  assign o_pc    = sel ? b_pc    : a_pc;
  assign o_c     = sel ? b_c     : a_c;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int gnt_pct, ready_pct, redir_pct, fixed_lat, max_lat;
  bit stale_rv, force_redir;
  logic [31:0] force_pc;
  logic [31:0] mem [256];
  logic [31:0] rsp_addr [$];
  int          rsp_due [$];
  ent_t        acc_q [$];
  int          n_acc;
  logic        ob_req, ob_valid, ob_c;
  logic [31:0] ob_addr, ob_inst, ob_pc;

  function automatic logic [15:0] mhw(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[9:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Instruction at pc as seen by an RV32IC decoder reading memory directly.
  function automatic void ref_inst(input logic [31:0] pc, output logic [31:0] inst,
                                   output logic c, output logic [31:0] npc);
    logic [15:0] lo, hi;
    lo   = mhw(pc);
    hi   = mhw(pc + 32'd2);
    c    = lo[1:0] != 2'b11;
    inst = c ? {16'h0, lo} : {hi, lo};
    npc  = pc + (c ? 32'd2 : 32'd4);
  endfunction

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
  endtask

  // One clock: drive at negedge, sample 1ns later, update bench state at posedge.
  task automatic tick();
    ent_t e;
    int lat;
    imem_gnt_i   = ($urandom_range(0, 99) < gnt_pct);
    inst_ready_i = ($urandom_range(0, 99) < ready_pct);
    if (force_redir) begin
      redirect_i = 1'b1; redirect_pc_i = force_pc;
    end else if (!rst && $urandom_range(0, 99) < redir_pct) begin
      redirect_i = 1'b1; redirect_pc_i = $urandom_range(0, 1023);
    end else begin
      redirect_i = 1'b0; redirect_pc_i = $urandom;
    end
    if (stale_rv) begin
      imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    end else if (rsp_addr.size() > 0 && rsp_due[0] <= cyc) begin
      imem_rvalid_i = 1'b1; imem_rdata_i = mem[rsp_addr[0][9:2]];
    end else begin
      imem_rvalid_i = 1'b0; imem_rdata_i = $urandom;
    end
    #1;
    ob_req = o_req; ob_addr = o_addr; ob_valid = o_valid;
    ob_inst = o_inst; ob_pc = o_pc; ob_c = o_c;
    @(posedge clk);
    force_redir = 1'b0;
    if (rst) begin
      rsp_addr.delete(); rsp_due.delete();
    end else begin
      if (imem_rvalid_i && !stale_rv) begin
        void'(rsp_addr.pop_front()); void'(rsp_due.pop_front());
      end
      if (ob_req && imem_gnt_i) begin
        lat = (fixed_lat > 0) ? fixed_lat : $urandom_range(1, max_lat);
        rsp_addr.push_back(ob_addr); rsp_due.push_back(cyc + lat);
      end
      if (redirect_i) begin
        e.redir = 1'b1; e.pc = redirect_pc_i & ~32'h1; e.inst = '0; e.c = 1'b0;
        acc_q.push_back(e);
      end else if (ob_valid && inst_ready_i) begin
        e.redir = 1'b0; e.pc = ob_pc; e.inst = ob_inst; e.c = ob_c;
        acc_q.push_back(e); n_acc++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_knobs(input int g, input int r, input int fl);
    gnt_pct = g; ready_pct = r; fixed_lat = fl; max_lat = 3; redir_pct = 0;
    stale_rv = 1'b0; force_redir = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    acc_q.delete(); n_acc = 0;
  endtask

  task automatic run_acc(input int target, input int budget, output bit ok);
    int k = 0;
    while (n_acc < target && k < budget) begin tick(); k++; end
    ok = (n_acc >= target);
  endtask

  task automatic test_reset();
    sel = 1'b0; set_knobs(0, 100, 1); fill_nop();
    rst = 1'b1; tick(); tick();
    total++; if (ob_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ob_valid); end
    total++; if (ob_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", ob_req); end
    total++; if (ob_inst !== 32'h0) begin bad++; $display("FAIL reset_inst: got %h want 0", ob_inst); end
    rst = 1'b0; acc_q.delete(); n_acc = 0;
    tick();
    total++; if (ob_req !== 1'b1) begin bad++; $display("FAIL post_reset_req: got %b want 1", ob_req); end
    total++; if (ob_addr !== 32'h0) begin bad++; $display("FAIL post_reset_addr: got %h want 0", ob_addr); end
    total++; if (ob_valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid: got %b want 0", ob_valid); end
  endtask

  task automatic run_three(input string name, input logic [31:0] epc [3],
                           input logic [31:0] einst [3], input logic ec [3]);
    bit ok;
    run_acc(3, 60, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL %s_timeout: got %0d insts want 3", name, n_acc); end
    else for (int i = 0; i < 3; i++) begin
      total++;
      if (acc_q[i].pc !== epc[i] || acc_q[i].inst !== einst[i] || acc_q[i].c !== ec[i]) begin
        bad++;
        $display("FAIL %s_%0d: got pc=%h inst=%h c=%b want pc=%h inst=%h c=%b", name, i,
                 acc_q[i].pc, acc_q[i].inst, acc_q[i].c, epc[i], einst[i], ec[i]);
      end
    end
  endtask

  task automatic test_basic();
    int first_valid = -1;
    fill_nop(); mem[0] = 32'h0000_0013; mem[1] = 32'h4501_4501;
    sel = 1'b0; set_knobs(100, 100, 1); do_reset();
    for (int k = 0; k < 10 && first_valid < 0; k++) begin
      tick();
      if (ob_valid) first_valid = k;
    end
    total++;
    if (first_valid != 2) begin bad++; $display("FAIL first_valid_cycle: got %0d want 2", first_valid); end
    sel = 1'b0; do_reset();
    run_three("basic", '{32'h0, 32'h4, 32'h6}, '{32'h13, 32'h4501, 32'h4501}, '{1'b0, 1'b1, 1'b1});
  endtask

  task automatic test_straddle();
    fill_nop(); mem[0] = 32'h0013_4501; mem[1] = 32'h4501_0000;
    sel = 1'b0; set_knobs(100, 100, 1); do_reset();
    run_three("straddle", '{32'h0, 32'h2, 32'h6}, '{32'h4501, 32'h13, 32'h4501}, '{1'b1, 1'b0, 1'b1});
  endtask

  task automatic test_redirect_inflight();
    bit found = 0, ok;
    int mi = -1;
    fill_nop(); mem[2] = 32'hFFFF_FFFF; mem[64] = 32'h4585_1234;
    sel = 1'b0; set_knobs(100, 100, 3); do_reset();
    for (int k = 0; k < 60 && !found; k++) begin
      tick();
      found = ob_req && imem_gnt_i && (ob_addr == 32'h8);
    end
    total++;
    if (!found) begin bad++; $display("FAIL inflight_grant8: got none want grant at 0x8"); end
    force_redir = 1'b1; force_pc = 32'h102; tick();
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin tick(); found = ob_req; end
    total++;
    if (!found || ob_addr !== 32'h100) begin
      bad++; $display("FAIL inflight_next_addr: got req=%b addr=%h want 1/00000100", found, ob_addr);
    end
    run_acc(n_acc + 1, 60, ok);
    foreach (acc_q[i]) if (acc_q[i].redir) mi = i;
    total++;
    if (!ok || mi < 0 || mi + 1 >= acc_q.size()) begin
      bad++; $display("FAIL inflight_timeout: got %0d insts want first after redirect", n_acc);
    end else if (acc_q[mi+1].pc !== 32'h102 || acc_q[mi+1].inst !== 32'h4585 || acc_q[mi+1].c !== 1'b1) begin
      bad++; $display("FAIL inflight_first: got pc=%h inst=%h c=%b want 00000102/00004585/1",
                      acc_q[mi+1].pc, acc_q[mi+1].inst, acc_q[mi+1].c);
    end
  endtask

  task automatic test_stall();
    int grants = 0;
    bit ok;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013 | (32'(i) << 7);
    sel = 1'b0; set_knobs(100, 0, 1); do_reset();
    repeat (10) begin tick(); if (ob_req && imem_gnt_i) grants++; end
    total++; if (grants != 2) begin bad++; $display("FAIL stall_grants: got %0d want 2", grants); end
    total++; if (ob_req !== 1'b0) begin bad++; $display("FAIL stall_req_low: got %b want 0", ob_req); end
    total++;
    if (ob_valid !== 1'b1 || ob_pc !== 32'h0) begin
      bad++; $display("FAIL stall_head: got valid=%b pc=%h want 1/00000000", ob_valid, ob_pc);
    end
    ready_pct = 100;
    run_acc(8, 100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL stall_timeout: got %0d insts want 8", n_acc); end
    else for (int i = 0; i < 8; i++) begin
      total++;
      if (acc_q[i].pc !== 32'(i * 4) || acc_q[i].inst !== mem[i]) begin
        bad++; $display("FAIL stall_order_%0d: got pc=%h inst=%h want pc=%h inst=%h",
                        i, acc_q[i].pc, acc_q[i].inst, 32'(i * 4), mem[i]);
      end
    end
  endtask

  task automatic test_redirect_handshake();
    bit ok;
    int mi = -1, k = 0;
    fill_nop(); mem[16] = 32'h0000_0513;
    sel = 1'b0; set_knobs(100, 100, 1); do_reset();
    while (!o_valid && k < 30) begin tick(); k++; end
    force_redir = 1'b1; force_pc = 32'h40; tick();
    total++;
    if (ob_valid !== 1'b1) begin bad++; $display("FAIL hs_valid: got %b want 1", ob_valid); end
    run_acc(n_acc + 1, 40, ok);
    foreach (acc_q[i]) if (acc_q[i].redir) mi = i;
    total++;
    if (!ok || mi < 0 || mi + 1 >= acc_q.size()) begin
      bad++; $display("FAIL hs_timeout: got %0d insts want one after redirect", n_acc);
    end else if (acc_q[mi+1].pc !== 32'h40 || acc_q[mi+1].inst !== 32'h513 || acc_q[mi+1].c !== 1'b0) begin
      bad++; $display("FAIL hs_first: got pc=%h inst=%h c=%b want 00000040/00000513/0",
                      acc_q[mi+1].pc, acc_q[mi+1].inst, acc_q[mi+1].c);
    end
  endtask

  task automatic test_reset_midstream();
    int grants = 0, k = 0;
    bit ok;
    fill_nop(); mem[8] = 32'h0000_0113; mem[9] = 32'h0000_0193;
    sel = 1'b1; set_knobs(100, 0, 4); do_reset();
    while (grants < 2 && k < 40) begin tick(); k++; if (ob_req && imem_gnt_i) grants++; end
    rst = 1'b1; tick(); tick();
    total++; if (ob_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", ob_valid); end
    total++; if (ob_req !== 1'b0) begin bad++; $display("FAIL midrst_req: got %b want 0", ob_req); end
    rst = 1'b0; acc_q.delete(); n_acc = 0;
    gnt_pct = 0; ready_pct = 100; stale_rv = 1'b1; tick();
    stale_rv = 1'b0; gnt_pct = 100;
    total++;
    if (ob_req !== 1'b1 || ob_addr !== 32'h20) begin
      bad++; $display("FAIL midrst_addr: got req=%b addr=%h want 1/00000020", ob_req, ob_addr);
    end
    run_acc(2, 60, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL midrst_timeout: got %0d insts want 2", n_acc); end
    else if (acc_q[0].pc !== 32'h20 || acc_q[0].inst !== 32'h113 || acc_q[1].pc !== 32'h24) begin
      bad++; $display("FAIL midrst_first: got pc=%h inst=%h next=%h want 00000020/00000113/00000024",
                      acc_q[0].pc, acc_q[0].inst, acc_q[1].pc);
    end
    sel = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] mpc, ei, npc;
    logic ec;
    int nprint = 0;
    logic [15:0] lo, hi;
    for (int i = 0; i < 256; i++) begin
      lo = $urandom; hi = $urandom;
      if ($urandom_range(0, 1) == 1) lo[1:0] = 2'b11; else lo[1:0] = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) hi[1:0] = 2'b11; else hi[1:0] = 2'($urandom_range(0, 2));
      mem[i] = {hi, lo};
    end
    sel = 1'b0; set_knobs(70, 70, 0); do_reset();
    force_redir = 1'b1; force_pc = 32'hFFFF_FFFE;
    redir_pct = 3;
    repeat (2000) tick();
    redir_pct = 0;
    mpc = 32'h0;
    foreach (acc_q[i]) begin
      if (acc_q[i].redir) mpc = acc_q[i].pc;
      else begin
        ref_inst(mpc, ei, ec, npc);
        total++;
        if (acc_q[i].pc !== mpc || acc_q[i].inst !== ei || acc_q[i].c !== ec) begin
          bad++;
          if (nprint < 10)
            $display("FAIL random_%0d: got pc=%h inst=%h c=%b want pc=%h inst=%h c=%b",
                     i, acc_q[i].pc, acc_q[i].inst, acc_q[i].c, mpc, ei, ec);
          nprint++;
        end
        mpc = npc;
      end
    end
    total++;
    if (n_acc < 200) begin bad++; $display("FAIL random_progress: got %0d insts want >=200", n_acc); end
  endtask

  initial begin
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0; inst_ready_i = 1'b0; sel = 1'b0;
    set_knobs(0, 0, 1);
    @(negedge clk);
    test_reset();
    test_basic();
    test_straddle();
    test_redirect_inflight();
    test_stall();
    test_redirect_handshake();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
